// File: rtl/spram_arb_pkg.sv
// Shared types and defaults for the two-port round-robin front end of a single-port RAM.
package spram_arb_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 6;

  typedef logic reqId_t;

  typedef struct packed {
    logic   valid;
    reqId_t id;
  } rdTag_t;

  localparam rdTag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so the other side wins a tie.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output reqId_t     winner_o
);

  reqId_t lastGnt_q, lastGnt_d;

  // A lone requester always wins; on a tie the side that did not win last time goes.
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = lastGnt_q ? 2'b01 : 2'b10;
    end
    winner_o  = gnt_o[1];
    lastGnt_d = (|gnt_o) ? gnt_o[1] : lastGnt_q;
  end

  // Reset to 1 so requester 0 takes the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGnt_q <= 1'b1;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Shares one single-port RAM between two requesters with round-robin grants and tagged read returns.
// Optional SPRAM_ARB_CONFLICT_CNT_EN adds a saturating count of cycles where both requesters asked.
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  logic [1:0] req, gnt;
  reqId_t     winner;
  rdTag_t     newTag, outTag;
  rdTag_t     tagPipe_q [RD_LAT];
  rdTag_t     tagPipe_d [RD_LAT];
  logic [DW-1:0] rdata0_q, rdata1_q;

  // Requests are masked during reset so no grant or RAM write escapes.
  assign req = {r1_req, r0_req} & {2{~rst}};

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    newTag   = TAG_IDLE;
    if (|gnt) begin
      ram_we       = winner ? r1_we    : r0_we;
      ram_addr     = winner ? r1_addr  : r0_addr;
      ram_data     = winner ? r1_wdata : r0_wdata;
      newTag.valid = ~ram_we;
      newTag.id    = winner;
    end
  end

  // Tags ride alongside the RAM read latency and pop out as q becomes valid.
  always_comb begin
    tagPipe_d    = tagPipe_q;
    tagPipe_d[0] = newTag;
    for (int i = 1; i < RD_LAT; i++) begin
      tagPipe_d[i] = tagPipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tagPipe_q[i] <= TAG_IDLE;
      end
    end else begin
      tagPipe_q <= tagPipe_d;
    end
  end

  assign outTag    = tagPipe_q[RD_LAT-1];
  assign r0_rvalid = outTag.valid && (outTag.id == 1'b0);
  assign r1_rvalid = outTag.valid && (outTag.id == 1'b1);

  // Read data follows q in the valid cycle and otherwise holds the last response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (r0_rvalid) rdata0_q <= ram_q;
      if (r1_rvalid) rdata1_q <= ram_q;
    end
  end

  assign r0_rdata = r0_rvalid ? ram_q : rdata0_q;
  assign r1_rdata = r1_rvalid ? ram_q : rdata1_q;

`ifdef SPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflictCnt_q, conflictCnt_d;

  always_comb begin
    conflictCnt_d = conflictCnt_q;
    if (r0_req && r1_req && (conflictCnt_q != 16'hFFFF)) begin
      conflictCnt_d = conflictCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflictCnt_q <= '0;
    end else begin
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign conflict_cnt = conflictCnt_q;
`endif

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter: one RD_LAT=1 instance and one RD_LAT=3 instance, each with a RAM model.
module tb_spram_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // RD_LAT=1 instance signals
  logic       r0Req, r0We, r1Req, r1We;
  logic [5:0] r0Addr, r1Addr;
  logic [7:0] r0Wdata, r1Wdata;
  logic       r0Gnt, r0Rvalid, r1Gnt, r1Rvalid;
  logic [7:0] r0Rdata, r1Rdata;
  logic [7:0] ramData, ramQ;
  logic [5:0] ramAddr;
  logic       ramWe;
  logic [7:0] mem0 [64];
  logic [5:0] ramAddrQ0;

  // RD_LAT=3 instance signals
  logic       s0Req, s0We, s1Req, s1We;
  logic [5:0] s0Addr, s1Addr;
  logic [7:0] s0Wdata, s1Wdata;
  logic       s0Gnt, s0Rvalid, s1Gnt, s1Rvalid;
  logic [7:0] s0Rdata, s1Rdata;
  logic [7:0] ram3Data, ram3Q;
  logic [5:0] ram3Addr;
  logic       ram3We;
  logic [7:0] mem3 [64];
  logic [5:0] ram3AddrQ;
  logic [7:0] q3Pipe0, q3Pipe1;

`ifdef SPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflictCnt, conflictCnt3;
`endif

  // Single-port RAM models with a registered read address; the slow one adds two output stages.
  always_ff @(posedge clk) begin
    if (ramWe) mem0[ramAddr] <= ramData;
    ramAddrQ0 <= ramAddr;
    if (ram3We) mem3[ram3Addr] <= ram3Data;
    ram3AddrQ <= ram3Addr;
    q3Pipe0   <= mem3[ram3AddrQ];
    q3Pipe1   <= q3Pipe0;
  end

  assign ramQ  = mem0[ramAddrQ0];
  assign ram3Q = q3Pipe1;

  spram_rr_arbiter #(.DW(8), .AW(6), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0Req), .r0_we(r0We), .r0_addr(r0Addr), .r0_wdata(r0Wdata),
    .r0_gnt(r0Gnt), .r0_rvalid(r0Rvalid), .r0_rdata(r0Rdata),
    .r1_req(r1Req), .r1_we(r1We), .r1_addr(r1Addr), .r1_wdata(r1Wdata),
    .r1_gnt(r1Gnt), .r1_rvalid(r1Rvalid), .r1_rdata(r1Rdata),
    .ram_data(ramData), .ram_addr(ramAddr), .ram_we(ramWe), .ram_q(ramQ)
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflictCnt)
`endif
  );

  spram_rr_arbiter #(.DW(8), .AW(6), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_req(s0Req), .r0_we(s0We), .r0_addr(s0Addr), .r0_wdata(s0Wdata),
    .r0_gnt(s0Gnt), .r0_rvalid(s0Rvalid), .r0_rdata(s0Rdata),
    .r1_req(s1Req), .r1_we(s1We), .r1_addr(s1Addr), .r1_wdata(s1Wdata),
    .r1_gnt(s1Gnt), .r1_rvalid(s1Rvalid), .r1_rdata(s1Rdata),
    .ram_data(ram3Data), .ram_addr(ram3Addr), .ram_we(ram3We), .ram_q(ram3Q)
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflictCnt3)
`endif
  );

  task automatic idle0();
    r0Req = 1'b0; r0We = 1'b0; r0Addr = '0; r0Wdata = '0;
    r1Req = 1'b0; r1We = 1'b0; r1Addr = '0; r1Wdata = '0;
  endtask

  task automatic idle3();
    s0Req = 1'b0; s0We = 1'b0; s0Addr = '0; s0Wdata = '0;
    s1Req = 1'b0; s1We = 1'b0; s1Addr = '0; s1Wdata = '0;
  endtask

  // Requests held high during reset must not be granted or reach the RAM.
  task automatic test_reset();
    rst = 1'b1;
    idle0(); idle3();
    r0Req = 1'b1; r0We = 1'b1; r0Addr = 6'd5; r0Wdata = 8'h55;
    r1Req = 1'b1; r1We = 1'b1; r1Addr = 6'd6; r1Wdata = 8'h66;
    s1Req = 1'b1; s1We = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (r0Gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_r0_gnt got %b want 0", r0Gnt); end
    checks++; if (r1Gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_r1_gnt got %b want 0", r1Gnt); end
    checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got %b want 0", ramWe); end
    checks++; if (r0Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_r0_rvalid got %b want 0", r0Rvalid); end
    checks++; if (r1Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_r1_rvalid got %b want 0", r1Rvalid); end
    checks++; if (s1Gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_s1_gnt got %b want 0", s1Gnt); end
    checks++; if (ram3We !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram3_we got %b want 0", ram3We); end
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
    checks++; if (conflictCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_conflict_cnt got %0d want 0", conflictCnt); end
`endif
    idle0(); idle3();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    idle0();
    r0Req = 1'b1; r0We = 1'b1; r0Addr = 6'd0; r0Wdata = 8'h01;
    #1;
    checks++; if (r0Gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr0_gnt got %b want 1", r0Gnt); end
    checks++; if (r1Gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr0_r1_gnt got %b want 0", r1Gnt); end
    checks++; if (ramWe !== 1'b1) begin errors++; $display("[TB] FAIL wr0_ram_we got %b want 1", ramWe); end
    checks++; if (ramData !== 8'h01) begin errors++; $display("[TB] FAIL wr0_ram_data got %h want 01", ramData); end
    @(negedge clk);
    idle0();
    r1Req = 1'b1; r1We = 1'b1; r1Addr = 6'd1; r1Wdata = 8'h02;
    #1;
    checks++; if (r1Gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr1_gnt got %b want 1", r1Gnt); end
    checks++; if (r0Gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr1_r0_gnt got %b want 0", r0Gnt); end
    checks++; if (ramWe !== 1'b1) begin errors++; $display("[TB] FAIL wr1_ram_we got %b want 1", ramWe); end
    checks++; if (ramAddr !== 6'd1) begin errors++; $display("[TB] FAIL wr1_ram_addr got %0d want 1", ramAddr); end
    checks++; if (ramData !== 8'h02) begin errors++; $display("[TB] FAIL wr1_ram_data got %h want 02", ramData); end
    @(negedge clk);
    idle0();
    #1;
    checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL idle_ram_we got %b want 0", ramWe); end
    checks++; if (ramAddr !== 6'd0) begin errors++; $display("[TB] FAIL idle_ram_addr got %0d want 0", ramAddr); end
    checks++; if (ramData !== 8'h00) begin errors++; $display("[TB] FAIL idle_ram_data got %h want 00", ramData); end
    checks++; if (mem0[0] !== 8'h01) begin errors++; $display("[TB] FAIL ram_word0 got %h want 01", mem0[0]); end
    checks++; if (mem0[1] !== 8'h02) begin errors++; $display("[TB] FAIL ram_word1 got %h want 02", mem0[1]); end
  endtask

  // Simultaneous reads after r1's write: r0 wins, r1 follows, responses one cycle apart.
  task automatic test_conflict_read();
    @(negedge clk);
    r0Req = 1'b1; r0We = 1'b0; r0Addr = 6'd0;
    r1Req = 1'b1; r1We = 1'b0; r1Addr = 6'd1;
    #1;
    checks++; if (r0Gnt !== 1'b1) begin errors++; $display("[TB] FAIL cf_r0_gnt got %b want 1", r0Gnt); end
    checks++; if (r1Gnt !== 1'b0) begin errors++; $display("[TB] FAIL cf_r1_gnt0 got %b want 0", r1Gnt); end
    checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL cf_ram_we got %b want 0", ramWe); end
    @(negedge clk);
    r0Req = 1'b0;
    #1;
    checks++; if (r1Gnt !== 1'b1) begin errors++; $display("[TB] FAIL cf_r1_gnt got %b want 1", r1Gnt); end
    checks++; if (ramAddr !== 6'd1) begin errors++; $display("[TB] FAIL cf_ram_addr got %0d want 1", ramAddr); end
    checks++; if (r0Rvalid !== 1'b1) begin errors++; $display("[TB] FAIL cf_r0_rvalid got %b want 1", r0Rvalid); end
    checks++; if (r0Rdata !== 8'h01) begin errors++; $display("[TB] FAIL cf_r0_rdata got %h want 01", r0Rdata); end
    checks++; if (r1Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL cf_r1_rvalid_early got %b want 0", r1Rvalid); end
    @(negedge clk);
    r1Req = 1'b0;
    #1;
    checks++; if (r1Rvalid !== 1'b1) begin errors++; $display("[TB] FAIL cf_r1_rvalid got %b want 1", r1Rvalid); end
    checks++; if (r1Rdata !== 8'h02) begin errors++; $display("[TB] FAIL cf_r1_rdata got %h want 02", r1Rdata); end
    checks++; if (r0Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL cf_r0_rvalid_pulse got %b want 0", r0Rvalid); end
    checks++; if (r0Rdata !== 8'h01) begin errors++; $display("[TB] FAIL cf_r0_rdata_hold got %h want 01", r0Rdata); end
    @(negedge clk);
    #1;
    checks++; if (r1Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL cf_r1_rvalid_pulse got %b want 0", r1Rvalid); end
    checks++; if (r1Rdata !== 8'h02) begin errors++; $display("[TB] FAIL cf_r1_rdata_hold got %h want 02", r1Rdata); end
  endtask

  // Both requesters held for six cycles; r1 won last, so grants run 0,1,0,1,0,1.
  task automatic test_alternate();
    logic expR0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r0Req = 1'b1; r0We = 1'b0; r0Addr = 6'd0;
      r1Req = 1'b1; r1We = 1'b0; r1Addr = 6'd1;
      #1;
      expR0 = ((i % 2) == 0);
      checks++; if (r0Gnt !== expR0) begin errors++; $display("[TB] FAIL alt%0d_r0_gnt got %b want %b", i, r0Gnt, expR0); end
      checks++; if (r1Gnt !== ~expR0) begin errors++; $display("[TB] FAIL alt%0d_r1_gnt got %b want %b", i, r1Gnt, ~expR0); end
      if (i > 0) begin
        checks++; if (r0Rvalid !== ~expR0) begin errors++; $display("[TB] FAIL alt%0d_r0_rvalid got %b want %b", i, r0Rvalid, ~expR0); end
      end
    end
    @(negedge clk);
    idle0();
    #1;
    checks++; if (r1Rvalid !== 1'b1) begin errors++; $display("[TB] FAIL alt_last_r1_rvalid got %b want 1", r1Rvalid); end
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
    checks++; if (conflictCnt !== 16'd7) begin errors++; $display("[TB] FAIL alt_conflict_cnt got %0d want 7", conflictCnt); end
`endif
  endtask

  task automatic test_raw();
    @(negedge clk);
    idle0();
    r1Req = 1'b1; r1We = 1'b1; r1Addr = 6'd1; r1Wdata = 8'h04;
    #1;
    checks++; if (r1Gnt !== 1'b1) begin errors++; $display("[TB] FAIL raw_wr_gnt got %b want 1", r1Gnt); end
    @(negedge clk);
    r1We = 1'b0; r1Wdata = 8'h00;
    #1;
    checks++; if (r1Gnt !== 1'b1) begin errors++; $display("[TB] FAIL raw_rd_gnt got %b want 1", r1Gnt); end
    checks++; if (r1Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL raw_no_wr_rvalid got %b want 0", r1Rvalid); end
    @(negedge clk);
    idle0();
    #1;
    checks++; if (r1Rvalid !== 1'b1) begin errors++; $display("[TB] FAIL raw_rvalid got %b want 1", r1Rvalid); end
    checks++; if (r1Rdata !== 8'h04) begin errors++; $display("[TB] FAIL raw_rdata got %h want 04", r1Rdata); end
  endtask

  // r0 read in flight when reset hits: its response must vanish and the pointer must return to 1.
  task automatic test_reset_mid_read();
    @(negedge clk);
    idle0();
    r0Req = 1'b1; r0We = 1'b0; r0Addr = 6'd0;
    #1;
    checks++; if (r0Gnt !== 1'b1) begin errors++; $display("[TB] FAIL mr_gnt got %b want 1", r0Gnt); end
    @(negedge clk);
    rst = 1'b1;
    r0Req = 1'b1; r0We = 1'b1; r0Addr = 6'd9; r0Wdata = 8'h99;
    r1Req = 1'b1; r1We = 1'b1; r1Addr = 6'd9; r1Wdata = 8'h88;
    #1;
    checks++; if (r0Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL mr_r0_rvalid got %b want 0", r0Rvalid); end
    checks++; if (r0Rdata !== 8'h00) begin errors++; $display("[TB] FAIL mr_r0_rdata got %h want 00", r0Rdata); end
    checks++; if (r1Rdata !== 8'h00) begin errors++; $display("[TB] FAIL mr_r1_rdata got %h want 00", r1Rdata); end
    checks++; if (r0Gnt !== 1'b0) begin errors++; $display("[TB] FAIL mr_r0_gnt got %b want 0", r0Gnt); end
    checks++; if (r1Gnt !== 1'b0) begin errors++; $display("[TB] FAIL mr_r1_gnt got %b want 0", r1Gnt); end
    checks++; if (ramWe !== 1'b0) begin errors++; $display("[TB] FAIL mr_ram_we got %b want 0", ramWe); end
    checks++; if (ramAddr !== 6'd0) begin errors++; $display("[TB] FAIL mr_ram_addr got %0d want 0", ramAddr); end
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
    checks++; if (conflictCnt !== 16'd0) begin errors++; $display("[TB] FAIL mr_conflict_cnt got %0d want 0", conflictCnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    r0Req = 1'b1; r0We = 1'b0; r0Addr = 6'd0;
    r1Req = 1'b1; r1We = 1'b0; r1Addr = 6'd1;
    #1;
    checks++; if (r0Gnt !== 1'b1) begin errors++; $display("[TB] FAIL mr_post_r0_gnt got %b want 1", r0Gnt); end
    checks++; if (r1Gnt !== 1'b0) begin errors++; $display("[TB] FAIL mr_post_r1_gnt got %b want 0", r1Gnt); end
    checks++; if (r0Rvalid !== 1'b0) begin errors++; $display("[TB] FAIL mr_post_r0_rvalid got %b want 0", r0Rvalid); end
    @(negedge clk);
    idle0();
  endtask

  // RD_LAT=3 instance: four alternating reads, each answered three cycles after its grant.
  task automatic test_rdlat3();
    logic       expValid;
    logic       expId;
    logic [7:0] expData;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle3();
      if ((k % 2) == 0) begin
        s0Req = 1'b1; s0We = 1'b1; s0Addr = 6'(10 + k); s0Wdata = 8'(8'hA0 + k);
      end else begin
        s1Req = 1'b1; s1We = 1'b1; s1Addr = 6'(10 + k); s1Wdata = 8'(8'hA0 + k);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle3();
      if (c < 4) begin
        if ((c % 2) == 0) begin
          s0Req = 1'b1; s0Addr = 6'(10 + c);
        end else begin
          s1Req = 1'b1; s1Addr = 6'(10 + c);
        end
      end
      #1;
      if (c < 4) begin
        checks++;
        if (((c % 2) == 0 && s0Gnt !== 1'b1) || ((c % 2) == 1 && s1Gnt !== 1'b1)) begin
          errors++; $display("[TB] FAIL l3_gnt%0d got %b%b want id %0d", c, s1Gnt, s0Gnt, c % 2);
        end
      end
      expValid = (c >= 3) && (c < 7);
      expId    = 1'((c - 3) % 2);
      expData  = 8'(8'hA0 + c - 3);
      checks++; if (s0Rvalid !== (expValid && !expId)) begin errors++; $display("[TB] FAIL l3_s0_rvalid%0d got %b want %b", c, s0Rvalid, expValid && !expId); end
      checks++; if (s1Rvalid !== (expValid && expId)) begin errors++; $display("[TB] FAIL l3_s1_rvalid%0d got %b want %b", c, s1Rvalid, expValid && expId); end
      if (expValid) begin
        checks++;
        if ((expId ? s1Rdata : s0Rdata) !== expData) begin
          errors++; $display("[TB] FAIL l3_rdata%0d got %h want %h", c, expId ? s1Rdata : s0Rdata, expData);
        end
      end
    end
`ifdef SPRAM_ARB_CONFLICT_CNT_EN
    checks++; if (conflictCnt3 !== 16'd0) begin errors++; $display("[TB] FAIL l3_conflict_cnt got %0d want 0", conflictCnt3); end
`endif
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write();
    test_conflict_read();
    test_alternate();
    test_raw();
    test_reset_mid_read();
    test_rdlat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
